stream_checker: RTL
===================

STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 Parameter: GAP_LIMIT, 64, CHECK-state cycles without a strobe before stall is flagged (range 2..65535).
REQ-002 Parameter: ERR_W, 16, width of err_count.
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: en  in  1  checker enable; 0 forces IDLE.
REQ-006 Port: s32  in  32  received stream word.
REQ-007 Port: s32rdy  in  1  one-cycle strobe qualifying s32.
REQ-008 Port: locked  out  1  high while in CHECK.
REQ-009 Port: err  out  1  one-cycle pulse per mismatching word.
REQ-010 Port: err_count  out  ERR_W  saturating mismatch count.
REQ-011 Port: word_count  out  32  strobes accepted in SYNC/CHECK, wraps mod 2^32.
REQ-012 Port: first_bad_exp  out  32  expected value at first mismatch.
REQ-013 Port: first_bad_got  out  32  received value at first mismatch.
REQ-014 Port: stall  out  1  sticky gap-watchdog flag.

Function
REQ-015 The FSM SHALL have states IDLE, SYNC, CHECK; all outputs registered, updated the cycle after the strobe edge (latency 1).
REQ-016 IDLE: s32rdy ignored; en=1 -> SYNC next cycle.
REQ-017 Any state with en=0 -> IDLE next cycle; locked=0; counters, first_bad_*, stall hold.
REQ-018 SYNC: first s32rdy seeds expected = s32+1 (mod 2^32), increments word_count, no compare, -> CHECK.
REQ-019 CHECK on s32rdy: word_count+1; s32==expected -> expected+1, err=0.
REQ-020 CHECK on s32rdy with s32!=expected: err=1 for one cycle, err_count+1 saturating at all-ones, expected per REQ-030/031.
REQ-021 first_bad_exp/first_bad_got SHALL load only on the mismatch taking err_count from 0; never overwritten afterwards.
REQ-022 Expected 32'hFFFFFFFF followed by 32'h00000000 SHALL be a match (wrap legal).
REQ-023 Gap counter: counts CHECK cycles without s32rdy; cleared by s32rdy or leaving CHECK; reaching GAP_LIMIT sets stall, which holds until rst.
REQ-024 s32rdy on the same cycle en falls SHALL be ignored.
REQ-025 Leaving and re-entering via en toggle SHALL reseed in SYNC; err_count, word_count, first_bad_* preserved.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, expected=0, gap counter=0.
REQ-027 Reset outputs: locked=0, err=0, err_count=0, word_count=0, first_bad_exp=0, first_bad_got=0, stall=0.
REQ-028 rst SHALL take priority over en and s32rdy, including mid-CHECK.
REQ-029 No asynchronous reset path SHALL exist.

Configuration
REQ-030 With STREAM_CHECKER_RESYNC_EN defined: after mismatch expected = s32+1 (tracks received stream; one gap = one error).
REQ-031 Without STREAM_CHECKER_RESYNC_EN: after mismatch expected = expected+1 (fixed reference; an offset stream errors on every word).

Verification
REQ-032 en=1, strobes every 10 cycles carrying 0..99 -> locked=1 after first, err never 1, err_count=0, word_count=100, stall=0.
REQ-033 Sequence 5,6,8,9,10: RESYNC_EN -> err_count=1; not defined -> err_count=3; both first_bad_exp=7, first_bad_got=8.
REQ-034 Sequence FFFFFFFE, FFFFFFFF, 0, 1 -> err_count=0, word_count=4.
REQ-035 GAP_LIMIT=64: in CHECK, no strobe for 64 cycles -> stall=1 and stays 1 after strobes resume and en toggles; rst clears it.
REQ-036 ERR_W=4, no RESYNC_EN, 20 consecutive mismatches -> err_count=15 held; rst asserted mid-CHECK -> all outputs reset next cycle, state IDLE.

Source files
------------

// File: rtl/stream_checker.sv
// stream_checker: incrementing-word stream checker with IDLE/SYNC/CHECK FSM, error capture and gap watchdog.
// Optional STREAM_CHECKER_RESYNC_EN: reseed expected from the received word after a mismatch.
module stream_checker #(
    parameter int GAP_LIMIT = 64,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      s32,
    input  logic             s32rdy,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      word_count,
    output logic [31:0]      first_bad_exp,
    output logic [31:0]      first_bad_got,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;
    state_t      state;
    logic [31:0] expected;
    logic [15:0] gap;
    logic        mismatch;
    logic [31:0] next_exp;
    assign mismatch = s32 != expected;
`ifdef STREAM_CHECKER_RESYNC_EN
    assign next_exp = s32 + 32'd1;
`else
    assign next_exp = expected + 32'd1;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            expected      <= '0;
            gap           <= '0;
            locked        <= 1'b0;
            err           <= 1'b0;
            err_count     <= '0;
            word_count    <= '0;
            first_bad_exp <= '0;
            first_bad_got <= '0;
            stall         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!en) begin
                state  <= IDLE;
                locked <= 1'b0;
                gap    <= '0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: if (s32rdy) begin
                        expected   <= s32 + 32'd1;
                        word_count <= word_count + 32'd1;
                        state      <= CHECK;
                        locked     <= 1'b1;
                    end
                    CHECK: if (s32rdy) begin
                        word_count <= word_count + 32'd1;
                        expected   <= next_exp;
                        gap        <= '0;
                        if (mismatch) begin
                            err       <= 1'b1;
                            err_count <= (&err_count) ? err_count : err_count + 1'b1;
                            if (err_count == '0) begin
                                first_bad_exp <= expected;
                                first_bad_got <= s32;
                            end
                        end
                    end else begin
                        // gap saturates at the limit; stall is sticky until reset
                        gap <= (gap == 16'(GAP_LIMIT)) ? gap : gap + 16'd1;
                        if (gap == 16'(GAP_LIMIT - 1)) stall <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
